// File: rtl/muldiv_pkg.sv
// Shared types and constants for the M-extension sequencer and its iterative datapath.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // funct3[2] splits the M-extension into the multiply and divide/remainder families.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_seq_ctrl.sv
// Sequencer for the iterative shift-add multiplier / restoring divider in EXE:
// issues load/step strobes, freezes FE/DE/EXE, bubbles ME, and aborts on flush.
module muldiv_seq_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6,
  parameter int OP_W  = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_e_i,
  input  logic [OP_W-1:0]  op_e_i,
  input  logic             divisor_zero_i,
  input  logic             flush_i,
  output logic             dp_load_o,
  output logic             dp_step_o,
  output logic             dp_div_o,
  output logic             dp_fast_o,
  output logic             stall_o,
  output logic             bubble_m_o,
  output logic             result_valid_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o
);

  if ((2 ** CNT_W) <= XLEN) begin : g_cnt_w_chk
    $error("CNT_W too narrow for XLEN iterations");
  end
  if (OP_W < 3) begin : g_op_w_chk
    $error("OP_W must hold a full funct3");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;

  logic op_div;
  logic cnt_last;
  logic load, step, div, fast, stall, bubble, valid;
  logic unused_op;

  assign op_div    = is_div_op(op_e_i[2:0]);
  assign unused_op = ^op_e_i;
  assign cnt_last  = (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    load    = 1'b0;
    step    = 1'b0;
    div     = 1'b0;
    fast    = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    valid   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_e_i && !flush_i) begin
          load   = 1'b1;
          div    = op_div;
          stall  = 1'b1;
          bubble = 1'b1;
          div_d  = op_div;
          cnt_d  = '0;
          // Divide by zero has an architecturally fixed result; skip the iterations.
          if (op_div && divisor_zero_i) begin
            fast    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        step   = !flush_i;
        div    = div_q;
        stall  = 1'b1;
        bubble = 1'b1;
        if (cnt_last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // EXE advances this cycle, so the still-asserted request is the finished op.
      ST_DONE: begin
        valid   = !flush_i;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  // Outputs are held low for the whole reset window, even with a request pending.
  assign dp_load_o      = load   & ~rst_i;
  assign dp_step_o      = step   & ~rst_i;
  assign dp_div_o       = div    & ~rst_i;
  assign dp_fast_o      = fast   & ~rst_i;
  assign stall_o        = stall  & ~rst_i;
  assign bubble_m_o     = bubble & ~rst_i;
  assign result_valid_o = valid  & ~rst_i;
  assign busy_o         = (state_q != ST_IDLE) & ~rst_i;
  assign cnt_o          = cnt_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a cycle-count reference model.
module tb_muldiv_seq_ctrl;
  import muldiv_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;
  localparam int OP_W  = 3;

  logic             clk = 1'b0;
  logic             rst, req, dz, flush;
  logic [OP_W-1:0]  op;
  logic             dp_load, dp_step, dp_div, dp_fast, stall, bubble, rvalid, busy;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  muldiv_seq_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .OP_W(OP_W)) dut (
    .clk_i(clk), .rst_i(rst), .req_e_i(req), .op_e_i(op),
    .divisor_zero_i(dz), .flush_i(flush),
    .dp_load_o(dp_load), .dp_step_o(dp_step), .dp_div_o(dp_div), .dp_fast_o(dp_fast),
    .stall_o(stall), .bubble_m_o(bubble), .result_valid_o(rvalid),
    .busy_o(busy), .cnt_o(cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    assert (int'(cnt) < XLEN) else begin
      errors++;
      $display("FAIL cnt_bound: cnt=%0d limit=%0d", cnt, XLEN - 1);
    end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] o, input logic z, input logic f);
    @(negedge clk);
    req = r; op = o; dz = z; flush = f;
    #1;
  endtask

  // Reference model: an op is described by how many cycles have elapsed since its load.
  typedef struct {
    logic load, step, div, fast, stall, bubble, valid, busy;
    int   cnt;
  } exp_t;

  bit m_act, m_fast, m_div;
  int m_k;

  function automatic exp_t model_out();
    exp_t e;
    bit   fin;
    e = '{default: 0};
    if (!m_act) begin
      if (req && !flush) begin
        e.load = 1; e.div = op[2]; e.fast = op[2] && dz;
        e.stall = 1; e.bubble = 1;
      end
    end else begin
      e.busy = 1;
      fin = m_fast ? (m_k == 1) : (m_k == XLEN + 1);
      if (fin) begin
        e.valid = !flush;
      end else begin
        e.step = !flush; e.div = m_div; e.stall = 1; e.bubble = 1; e.cnt = m_k - 1;
      end
    end
    return e;
  endfunction

  task automatic model_upd();
    bit fin;
    fin = m_act && (m_fast ? (m_k == 1) : (m_k == XLEN + 1));
    if (flush) m_act = 0;
    else if (!m_act) begin
      if (req) begin m_act = 1; m_k = 1; m_fast = op[2] && dz; m_div = op[2]; end
    end else if (fin) m_act = 0;
    else m_k++;
  endtask

  task automatic check_all(input exp_t e);
    chk("load", dp_load, e.load);
    chk("step", dp_step, e.step);
    chk("fast", dp_fast, e.fast);
    chk("stall", stall, e.stall);
    chk("bubble", bubble, e.bubble);
    chk("valid", rvalid, e.valid);
    chk("busy", busy, e.busy);
    chk("cnt", cnt, e.cnt);
    if (e.load || e.step) chk("div", dp_div, e.div);
  endtask

  typedef struct {
    logic       req;
    logic [2:0] op;
    logic       dz, flush;
    logic       load, step, valid, stall, fast, busy;
  } vec_t;

  vec_t vt[9];

  initial begin
    int vcyc, stalls, done_at, b2b_ok;
    exp_t e;

    // Directed table, starting from IDLE after reset.
    vt[0] = '{1, F3_DIV,  1, 0, 1, 0, 0, 1, 1, 0};  // div-by-zero load
    vt[1] = '{1, F3_DIV,  1, 0, 0, 0, 1, 0, 0, 1};  // DONE, request still high: no reload
    vt[2] = '{0, F3_MUL,  0, 0, 0, 0, 0, 0, 0, 0};
    vt[3] = '{1, F3_DIVU, 0, 1, 0, 0, 0, 0, 0, 0};  // flush coincident with load
    vt[4] = '{0, F3_MUL,  0, 0, 0, 0, 0, 0, 0, 0};
    vt[5] = '{1, F3_MULH, 1, 0, 1, 0, 0, 1, 0, 0};  // MUL ignores divisor_zero
    vt[6] = '{1, F3_MULH, 1, 0, 0, 1, 0, 1, 0, 1};
    vt[7] = '{1, F3_MULH, 0, 1, 0, 0, 0, 1, 0, 1};  // flush in RUN kills the step
    vt[8] = '{0, F3_MUL,  0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1; req = 0; op = '0; dz = 0; flush = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", cnt, 0);
    @(negedge clk); rst = 0;

    foreach (vt[i]) begin
      drive(vt[i].req, vt[i].op, vt[i].dz, vt[i].flush);
      chk($sformatf("vec%0d_load", i), dp_load, vt[i].load);
      chk($sformatf("vec%0d_step", i), dp_step, vt[i].step);
      chk($sformatf("vec%0d_valid", i), rvalid, vt[i].valid);
      chk($sformatf("vec%0d_stall", i), stall, vt[i].stall);
      chk($sformatf("vec%0d_bubble", i), bubble, vt[i].stall);
      chk($sformatf("vec%0d_fast", i), dp_fast, vt[i].fast);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
    end

    // MUL full latency: load at 0, steps 1..XLEN, result at XLEN+1.
    stalls = 0; done_at = -1;
    for (int c = 0; c < 3 * XLEN; c++) begin
      drive(1, F3_MUL, 0, 0);
      if (stall) stalls++;
      if (c == 0) chk("mul_load", dp_load, 1);
      else if (c <= XLEN) begin
        chk("mul_step", dp_step, 1);
        chk("mul_cnt", cnt, c - 1);
        chk("mul_div", dp_div, 0);
      end
      if (rvalid) begin done_at = c; chk("mul_done_stall", stall, 0); break; end
    end
    chk("mul_done_cycle", done_at, XLEN + 1);
    chk("mul_stall_cycles", stalls, XLEN + 1);
    drive(0, F3_MUL, 0, 0);
    chk("mul_idle_after", busy, 0);

    // Flush during RUN at cnt=5.
    drive(1, F3_REM, 0, 0);
    vcyc = 0;
    while (!(busy && cnt == 5) && vcyc < 20) begin drive(1, F3_REM, 0, 0); vcyc++; end
    chk("flush_reach_cnt5", cnt, 5);
    drive(1, F3_REM, 0, 1);
    chk("flush_step", dp_step, 0);
    chk("flush_valid", rvalid, 0);
    drive(0, F3_MUL, 0, 0);
    chk("flush_busy_next", busy, 0);
    chk("flush_stall_next", stall, 0);
    chk("flush_valid_next", rvalid, 0);

    // Back-to-back DIVU then REMU.
    done_at = -1; b2b_ok = 0;
    for (int c = 0; c < 3 * XLEN; c++) begin
      drive(1, F3_DIVU, 0, 0);
      if (dp_load || dp_step) chk("b2b_div1", dp_div, 1);
      if (rvalid) begin done_at = c; break; end
    end
    chk("b2b_first_done", done_at, XLEN + 1);
    drive(1, F3_REMU, 0, 0);
    chk("b2b_second_load", dp_load, 1);
    chk("b2b_second_div", dp_div, 1);
    for (int c = 0; c < 3 * XLEN; c++) begin
      drive(1, F3_REMU, 0, 0);
      if (dp_step) chk("b2b_div2", dp_div, 1);
      if (rvalid) begin b2b_ok = 1; break; end
    end
    chk("b2b_second_done", b2b_ok, 1);
    drive(0, F3_MUL, 0, 0);

    // Asynchronous reset mid-RUN at cnt=10 with the request still high.
    drive(1, F3_MUL, 0, 0);
    vcyc = 0;
    while (!(busy && cnt == 10) && vcyc < 20) begin drive(1, F3_MUL, 0, 0); vcyc++; end
    chk("rst_reach_cnt10", cnt, 10);
    #1 rst = 1;
    #1;
    chk("rstrun_load", dp_load, 0);
    chk("rstrun_step", dp_step, 0);
    chk("rstrun_stall", stall, 0);
    chk("rstrun_bubble", bubble, 0);
    chk("rstrun_busy", busy, 0);
    chk("rstrun_cnt", cnt, 0);
    drive(0, F3_MUL, 0, 0);
    rst = 0;
    drive(0, F3_MUL, 0, 0);
    chk("rstrun_idle_after", busy, 0);

    // Randomized traffic against the reference model.
    m_act = 0; m_k = 0; m_fast = 0; m_div = 0;
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(99) < 75, 3'($urandom_range(7)),
            $urandom_range(99) < 30, $urandom_range(99) < 4);
      e = model_out();
      check_all(e);
      model_upd();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_seq_ctrl.md
Name: muldiv_seq_ctrl

Overview:
- Sequencer for the iterative M-extension unit (radix-2 shift-add multiplier / restoring divider) in the EXE stage of the 5-stage pipeline.
- Accepts a MUL/DIV/REM instruction held in the EXE latch and drives load/step strobes into the iterative datapath.
- Holds FE/DE/EXE frozen and injects bubbles into ME until the result is ready.
- Aborts cleanly on a branch-redirect flush from ME.

Parameters:
- XLEN, 32, operand width; sets the iteration count.
- CNT_W, 6, width of the iteration counter; must satisfy 2**CNT_W > XLEN.
- OP_W, 3, width of the funct3 op code.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_e_i  in  1  EXE latch holds a valid M-extension instruction
- op_e_i  in  OP_W  funct3 of that instruction; 0-3 = MUL family, 4-7 = DIV/REM family
- divisor_zero_i  in  1  rs2 operand in EXE is zero, from the datapath
- flush_i  in  1  pc_src from ME (branch redirect); same net that clears the FE/DE/EXE latches
- dp_load_o  out  1  load operands into the iterative datapath registers
- dp_step_o  out  1  perform one shift/add or shift/subtract iteration
- dp_div_o  out  1  1 = divide mode, 0 = multiply mode; valid whenever dp_load_o or dp_step_o is 1
- dp_fast_o  out  1  select the divide-by-zero constant result path
- stall_o  out  1  freeze the FE, DE and EXE latches (ANDed into the FE latch enable and the DE/EXE latch enables)
- bubble_m_o  out  1  clear the EXE->ME latch input
- result_valid_o  out  1  datapath result is final; EXE forwards it to ME this cycle
- busy_o  out  1  state != IDLE
- cnt_o  out  CNT_W  current iteration index, for the datapath and debug

Behaviour:
- States: IDLE, RUN, DONE.
- Registered state: 2-bit state and CNT_W-bit counter. All outputs are combinational from state, counter and inputs.
- Reset (async, rst_i=1): state IDLE, cnt 0. All outputs 0.
- Flush has top priority in every state. flush_i=1 forces next state IDLE and cnt 0, and forces dp_load_o, dp_step_o and result_valid_o to 0 in that cycle. stall_o and bubble_m_o follow the state, but the flush clear overrides the freeze.
- IDLE with req_e_i=1 and flush_i=0:
  - dp_load_o=1, dp_div_o=op_e_i[2], stall_o=1, bubble_m_o=1.
  - If op_e_i[2]=1 and divisor_zero_i=1: dp_fast_o=1, next state DONE.
  - Otherwise: next state RUN, cnt <= 0.
- IDLE with req_e_i=0: all outputs 0; stay in IDLE.
- RUN:
  - dp_step_o=1, stall_o=1, bubble_m_o=1, dp_div_o holds the latched op.
  - cnt increments each cycle.
  - When cnt==XLEN-1, next state DONE and cnt <= 0.
- DONE:
  - result_valid_o=1, stall_o=0, bubble_m_o=0; the EXE latch advances.
  - Next state IDLE unconditionally. The still-high req_e_i in this cycle must not retrigger a load.
- Op mode (op_e_i[2]) is latched at load, so dp_div_o is stable in RUN even if the inputs glitch.
- Latency: normal op occupies EXE for XLEN+2 cycles (1 load + XLEN steps + 1 done). The pipeline stall is XLEN+1 cycles. Divide-by-zero occupies EXE for 2 cycles (1-cycle stall).
- Back-to-back M-ops: the second op is seen in IDLE the cycle after DONE, so there is no dead cycle beyond IDLE.
- req_e_i deasserting in RUN (it cannot do so without a flush) is ignored; the counter completes.
- The counter never exceeds XLEN-1. Overflow is unreachable by construction; the bench checks this with an assertion.
- Interaction with the load-use stall: stall_o is ORed with the existing load-use stall at the pipeline top level. Both may be 1 at once with no conflict.

Decomposition:
- Shared package muldiv_pkg:
  - state enum (IDLE, RUN, DONE)
  - funct3 localparams (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
  - constant XLEN_DEF
- No sub-module. The counter and FSM stay in one module. The iterative datapath is a separate sibling block, not instantiated here.

Test Plan:
- Reset mid-RUN: assert rst_i at cnt=10 -> all outputs 0 immediately; state IDLE after release.
- MUL (op=0), XLEN=32: req_e_i rises at cycle 0.
  - cycle 0: dp_load_o=1.
  - cycles 1-32: dp_step_o=1.
  - cycle 33: result_valid_o=1, stall_o=0.
  - stall_o=1 for exactly 33 cycles.
- DIV (op=4) with divisor_zero_i=1 -> dp_fast_o=1 and dp_load_o=1 at cycle 0; result_valid_o=1 at cycle 1; 1 stall cycle; no dp_step_o.
- Flush during RUN at cnt=5 -> same cycle dp_step_o=0; next cycle busy_o=0 and stall_o=0; no result_valid_o pulse.
- Back-to-back DIVU then REMU: second dp_load_o appears exactly 1 cycle after the first result_valid_o; dp_div_o=1 throughout both.
- Flush coincident with load (IDLE, req_e_i=1, flush_i=1) -> dp_load_o=0; stays IDLE; busy_o=0 next cycle.
